// File: rtl/a78_pkg.sv
// Shared types and constants for the A78/A26 cartridge loader.
package a78_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREFIX = 3'd1,
    HEADER = 3'd2,
    REPLAY = 3'd3,
    BODY   = 3'd4,
    DONE   = 3'd5
  } state_e;

  // A78 header geometry (byte offsets within the downloaded file)
  localparam int HDR_LEN      = 128;
  localparam int HDR_MAGIC_LO = 1;
  localparam int HDR_SIZE     = 49;
  localparam int HDR_FLAGS    = 53;
  localparam int HDR_JOY0     = 55;
  localparam int HDR_JOY1     = 56;
  localparam int HDR_REGION   = 57;
  localparam int HDR_SAVE     = 58;

  // Bytes 0..5 are held back until we know whether the image has a header
  localparam int PFX_LEN = 6;

  localparam logic [39:0] HDR_MAGIC = 40'h41_54_41_52_49;  // "ATARI"

endpackage

// File: rtl/a78_hdr_regs.sv
// Prefix buffer (first six file bytes), magic detection and A78 header
// metadata capture.
module a78_hdr_regs
  import a78_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        pfx_we_i,
  input  logic        hdr_we_i,
  input  logic [6:0]  addr_i,
  input  logic [7:0]  data_i,
  input  logic [2:0]  rd_idx_i,
  output logic [7:0]  rd_data_o,
  output logic        magic_o,
  output logic [15:0] flags_o,
  output logic [31:0] size_o,
  output logic [7:0]  joy0_o,
  output logic [7:0]  joy1_o,
  output logic [7:0]  region_o,
  output logic [7:0]  save_o
);

  // Eight slots so every 3-bit index is legal; only 0..PFX_LEN-1 are written
  logic [7:0]  pfx_q [8];
  logic [15:0] flags_q;
  logic [31:0] size_q;
  logic [7:0]  joy0_q, joy1_q, region_q, save_q;

  // Magic is judged while byte 5 is on the bus, so the last letter comes
  // straight from the data input rather than from the buffer.
  assign magic_o = ({pfx_q[HDR_MAGIC_LO],     pfx_q[HDR_MAGIC_LO + 1],
                     pfx_q[HDR_MAGIC_LO + 2], pfx_q[HDR_MAGIC_LO + 3],
                     data_i} == HDR_MAGIC);

  assign rd_data_o = pfx_q[rd_idx_i];

  // Capture prefix bytes 0..5 in order of arrival
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      for (int i = 0; i < 8; i++) pfx_q[i] <= '0;
    end else if (pfx_we_i && (addr_i < 7'(PFX_LEN))) begin
      pfx_q[addr_i[2:0]] <= data_i;
    end
  end

  // Latch header metadata fields by file offset (size is big-endian)
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      flags_q  <= '0;
      size_q   <= '0;
      joy0_q   <= '0;
      joy1_q   <= '0;
      region_q <= '0;
      save_q   <= '0;
    end else if (hdr_we_i) begin
      case (addr_i)
        7'(HDR_SIZE):       size_q[31:24] <= data_i;
        7'(HDR_SIZE + 1):   size_q[23:16] <= data_i;
        7'(HDR_SIZE + 2):   size_q[15:8]  <= data_i;
        7'(HDR_SIZE + 3):   size_q[7:0]   <= data_i;
        7'(HDR_FLAGS):      flags_q[15:8] <= data_i;
        7'(HDR_FLAGS + 1):  flags_q[7:0]  <= data_i;
        7'(HDR_JOY0):       joy0_q        <= data_i;
        7'(HDR_JOY1):       joy1_q        <= data_i;
        7'(HDR_REGION):     region_q      <= data_i;
        7'(HDR_SAVE):       save_q        <= data_i;
        default: ;
      endcase
    end
  end

  assign flags_o  = flags_q;
  assign size_o   = size_q;
  assign joy0_o   = joy0_q;
  assign joy1_o   = joy1_q;
  assign region_o = region_q;
  assign save_o   = save_q;

endmodule

// File: rtl/a78_cart_loader.sv
// Turns the hps_io ioctl download stream into cart RAM writes, stripping an
// A78 header when present and publishing cart metadata and a loaded flag.
//
// Handshake: a byte is accepted on any cycle where ioctl_wr=1 and the block is
// not replaying. ioctl_wait=1 means the next strobe must be held off; it also
// rises combinationally in the cycle that delivers byte 5 of a headerless
// image (that byte itself is accepted). hps_io is expected to raise
// ioctl_download at least one cycle before the first strobe.
module a78_cart_loader #(
  parameter int ADDR_W   = 18,
  parameter int HDR_LEN  = a78_pkg::HDR_LEN,
  parameter int BIOS_IDX = 0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wr,
  output logic              cart_is_7800,
  output logic [15:0]       cart_flags,
  output logic [31:0]       hdr_size,
  output logic [7:0]        joy0_type,
  output logic [7:0]        joy1_type,
  output logic [7:0]        cart_region,
  output logic [7:0]        cart_save,
  output logic [31:0]       cart_size,
  output logic              cart_loaded,
  output logic              load_done,
  output logic [2:0]        dbg_state
);
  import a78_pkg::*;

  localparam logic [24:0] RAM_DEPTH = 25'(1) << ADDR_W;
  localparam logic [24:0] HDR_LEN_A = 25'(HDR_LEN);

  state_e state_q, state_d;

  logic              cart_dl, cart_dl_q, start;
  logic              acc_wr, byte5, magic, replay_last;
  logic [2:0]        pfx_cnt_q, pfx_cnt_d;
  logic [2:0]        rp_idx_q, rp_idx_d;
  logic              is7800_q, is7800_d;
  logic [31:0]       size_q, size_d;
  logic              loaded_q, loaded_d;
  logic              done_q, done_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic [7:0]        pfx_rd_data;
  logic [24:0]       body_off;
  logic              body_ok, body_in_range;
  logic [31:0]       body_len;
  logic [31:0]       rp_len;
  logic              enter_done;

  // Stream qualifiers
  assign cart_dl     = ioctl_download && (ioctl_index != 8'(BIOS_IDX));
  assign start       = cart_dl && !cart_dl_q && (state_q == IDLE || state_q == DONE);
  assign acc_wr      = ioctl_wr && cart_dl && (state_q != REPLAY);
  assign byte5       = acc_wr && (state_q == PREFIX) && (ioctl_addr == 25'(PFX_LEN - 1));
  assign replay_last = (rp_idx_q == pfx_cnt_q - 3'd1);
  assign enter_done  = (state_d == DONE) && (state_q != DONE);

  // Body offset relative to cart RAM; header bytes never reach here for A78
  assign body_off      = ioctl_addr - (is7800_q ? HDR_LEN_A : 25'd0);
  assign body_ok       = !(is7800_q && (ioctl_addr < HDR_LEN_A));
  assign body_in_range = (body_off < RAM_DEPTH);
  assign body_len      = body_in_range ? ({7'd0, body_off} + 32'd1) : {7'd0, RAM_DEPTH};
  assign rp_len        = {29'd0, rp_idx_q} + 32'd1;

  a78_hdr_regs u_hdr (
    .clk_i     (clk_sys),
    .rst_ni    (reset_n),
    .clear_i   (start),
    .pfx_we_i  (acc_wr && (state_q == PREFIX)),
    .hdr_we_i  (acc_wr && (state_q == HEADER) && (ioctl_addr < HDR_LEN_A)),
    .addr_i    (ioctl_addr[6:0]),
    .data_i    (ioctl_dout),
    .rd_idx_i  (rp_idx_q),
    .rd_data_o (pfx_rd_data),
    .magic_o   (magic),
    .flags_o   (cart_flags),
    .size_o    (hdr_size),
    .joy0_o    (joy0_type),
    .joy1_o    (joy1_type),
    .region_o  (cart_region),
    .save_o    (cart_save)
  );

  // State register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; end of download is taken as a level so a download that
  // closes during replay still finishes in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = PREFIX;
      PREFIX: begin
        if (!cart_dl)   state_d = (pfx_cnt_q == 3'd0) ? DONE : REPLAY;
        else if (byte5) state_d = magic ? HEADER : REPLAY;
      end
      REPLAY: if (replay_last) state_d = cart_dl ? BODY : DONE;
      HEADER: begin
        if (!cart_dl) state_d = DONE;
        else if (acc_wr && (ioctl_addr == HDR_LEN_A - 25'd1)) state_d = BODY;
      end
      BODY:    if (!cart_dl) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: stall and RAM write request for the next cycle
  always_comb begin
    ioctl_wait = (state_q == REPLAY) || (byte5 && !magic);
    ram_wr_d   = 1'b0;
    ram_addr_d = '0;
    ram_data_d = '0;
    if (state_q == REPLAY) begin
      ram_wr_d   = 1'b1;
      ram_addr_d = ADDR_W'(rp_idx_q);
      ram_data_d = pfx_rd_data;
    end else if (state_q == BODY && acc_wr && body_ok && body_in_range) begin
      ram_wr_d   = 1'b1;
      ram_addr_d = body_off[ADDR_W-1:0];
      ram_data_d = ioctl_dout;
    end
  end

  // Datapath next values: prefix count, replay index, header flag, size, flags
  always_comb begin
    pfx_cnt_d = pfx_cnt_q;
    rp_idx_d  = rp_idx_q;
    is7800_d  = is7800_q;
    size_d    = size_q;
    loaded_d  = loaded_q;
    done_d    = enter_done;
    if (start) begin
      pfx_cnt_d = '0;
      rp_idx_d  = '0;
      is7800_d  = 1'b0;
      size_d    = '0;
      loaded_d  = 1'b0;
    end
    case (state_q)
      PREFIX: begin
        rp_idx_d = '0;
        if (acc_wr && (ioctl_addr < 25'(PFX_LEN))) pfx_cnt_d = ioctl_addr[2:0] + 3'd1;
        if (byte5 && magic) is7800_d = 1'b1;
      end
      REPLAY: begin
        rp_idx_d = rp_idx_q + 3'd1;
        if (rp_len > size_q) size_d = rp_len;
      end
      BODY: if (acc_wr && body_ok && (body_len > size_q)) size_d = body_len;
      default: ;
    endcase
    if (enter_done) loaded_d = 1'b1;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cart_dl_q  <= 1'b0;
      pfx_cnt_q  <= '0;
      rp_idx_q   <= '0;
      is7800_q   <= 1'b0;
      size_q     <= '0;
      loaded_q   <= 1'b0;
      done_q     <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      cart_dl_q  <= cart_dl;
      pfx_cnt_q  <= pfx_cnt_d;
      rp_idx_q   <= rp_idx_d;
      is7800_q   <= is7800_d;
      size_q     <= size_d;
      loaded_q   <= loaded_d;
      done_q     <= done_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign ram_wr       = ram_wr_q;
  assign ram_addr     = ram_addr_q;
  assign ram_data     = ram_data_q;
  assign cart_is_7800 = is7800_q;
  assign cart_size    = size_q;
  assign cart_loaded  = loaded_q;
  assign load_done    = done_q;
  assign dbg_state    = state_q;

endmodule
